sort_host_ctrl: RTL

- Host-side controller for the bubble-sort engine and its 1024x32 SRAM.
- Streams an unsorted array into the SRAM, raises Start, waits for Finish, then streams the sorted array back out while checking signed non-decreasing order.
- Owns the SRAM port outside the sort phase and muxes in the engine's port during it.

---
 rtl/sort_host_pkg.sv | 26 ++
 rtl/sort_host_ctrl_sram_port_mux.sv | 34 +++
 rtl/sort_host_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sort_host_pkg.sv
// Shared definitions for the bubble-sort host controller.
// Holds the controller state encoding, default job and timeout sizes, and
// a signed comparison helper used for the unload ordering check.
package sort_host_pkg;

  localparam int unsigned LEN_DEFAULT     = 1024;
  localparam int unsigned TIMEOUT_DEFAULT = 10000;

  // Widest word the ordering helper supports; callers sign-extend to this.
  localparam int unsigned CMP_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SORT,
    UNLOAD_RD,
    UNLOAD_WAIT
  } state_t;

  // True when a > b as two's-complement values.
  function automatic logic signed_gt(input logic signed [CMP_W-1:0] a,
                                     input logic signed [CMP_W-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/sort_host_ctrl_sram_port_mux.sv
// SRAM port selector.
// Routes the sort engine's read/write port to the SRAM while sel is high
// (controller in SORT), otherwise routes the controller's own port.
// Ports:
//   sel                     - 1 selects the engine side
//   host_* / eng_*          - read address, write address, write data, write enable
//   raddr/waddr/wdata/wen   - to the SRAM
module sram_port_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              sel,
  input  logic [ADDR_W-1:0] host_raddr,
  input  logic [ADDR_W-1:0] host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_wen,
  input  logic [ADDR_W-1:0] eng_raddr,
  input  logic [ADDR_W-1:0] eng_waddr,
  input  logic [DATA_W-1:0] eng_wdata,
  input  logic              eng_wen,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wen
);

  always_comb begin
    raddr = sel ? eng_raddr : host_raddr;
    waddr = sel ? eng_waddr : host_waddr;
    wdata = sel ? eng_wdata : host_wdata;
    wen   = sel ? eng_wen   : host_wen;
  end

endmodule

// File: rtl/sort_host_ctrl.sv
// Host-side controller for the bubble-sort engine and its SRAM.
// Loads LEN words from the input stream into the SRAM, runs the engine
// (Start level until a rising Finish edge or a timeout), then streams the
// SRAM back out, flagging any signed descending pair as a sort error.
// Ports:
//   clk, rst                         - clock, async active-high reset
//   in_valid/in_ready/in_data        - unsorted input stream
//   out_valid/out_ready/out_data/out_last - sorted output stream
//   Start/Finish                     - engine handshake (levels)
//   eng_RAddr/eng_WAddr/eng_WData/eng_Wen - engine SRAM port
//   RAddr/RData/WAddr/WData/Wen      - SRAM port (RData one cycle after RAddr)
//   busy, sort_err, timeout          - status (errors sticky until next job)
module sort_host_ctrl
  import sort_host_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned LEN         = LEN_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              Start,
  input  logic              Finish,
  input  logic [ADDR_W-1:0] eng_RAddr,
  input  logic [ADDR_W-1:0] eng_WAddr,
  input  logic [DATA_W-1:0] eng_WData,
  input  logic              eng_Wen,
  output logic [ADDR_W-1:0] RAddr,
  input  logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] WAddr,
  output logic [DATA_W-1:0] WData,
  output logic              Wen,
  output logic              busy,
  output logic              sort_err,
  output logic              timeout
);

  localparam int unsigned   CW   = ADDR_W + 1;
  localparam int unsigned   TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [CW-1:0]     wcnt;
  logic [CW-1:0]     idx;
  logic [TW-1:0]     tcnt;
  logic              finish_q;
  logic              fresh;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] prev_q;

  logic              accept;
  logic              handshake;
  logic              finish_edge;
  logic              descending;
  logic [DATA_W-1:0] host_wdata;

  assign accept      = in_valid && in_ready && (state == IDLE || state == LOAD);
  assign handshake   = out_valid && out_ready && (state == UNLOAD_WAIT);
  assign finish_edge = Finish && !finish_q;
  assign host_wdata  = accept ? in_data : '0;
  assign descending  = signed_gt(CMP_W'($signed(prev_q)), CMP_W'($signed(out_data)));

  // On the first WAIT cycle the SRAM word is only on RData; forward it so a
  // word can leave every two cycles, then hold the captured copy.
  assign out_data = fresh ? RData : data_q;

  sram_port_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mux (
    .sel        (state == SORT),
    .host_raddr (idx[ADDR_W-1:0]),
    .host_waddr (wcnt[ADDR_W-1:0]),
    .host_wdata (host_wdata),
    .host_wen   (accept),
    .eng_raddr  (eng_RAddr),
    .eng_waddr  (eng_WAddr),
    .eng_wdata  (eng_WData),
    .eng_wen    (eng_Wen),
    .raddr      (RAddr),
    .waddr      (WAddr),
    .wdata      (WData),
    .wen        (Wen)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      idx       <= '0;
      tcnt      <= '0;
      finish_q  <= 1'b0;
      fresh     <= 1'b0;
      data_q    <= '0;
      prev_q    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      Start     <= 1'b0;
      busy      <= 1'b0;
      sort_err  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      finish_q <= Finish;
      fresh    <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            sort_err <= 1'b0;
            timeout  <= 1'b0;
            busy     <= 1'b1;
            if (LEN == 1) begin
              state    <= SORT;
              in_ready <= 1'b0;
              Start    <= 1'b1;
              tcnt     <= '0;
            end else begin
              state <= LOAD;
              wcnt  <= CW'(1);
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (wcnt == LAST) begin
              state    <= SORT;
              in_ready <= 1'b0;
              Start    <= 1'b1;
              wcnt     <= '0;
              tcnt     <= '0;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
          end
        end
        SORT: begin
          if (finish_edge) begin
            state <= UNLOAD_RD;
            Start <= 1'b0;
            idx   <= '0;
          end else if (tcnt == TLIM) begin
            state    <= IDLE;
            Start    <= 1'b0;
            timeout  <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        UNLOAD_RD: begin
          state     <= UNLOAD_WAIT;
          out_valid <= 1'b1;
          out_last  <= (idx == LAST);
          fresh     <= 1'b1;
        end
        UNLOAD_WAIT: begin
          if (fresh) data_q <= RData;
          if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            prev_q    <= out_data;
            if (idx != '0 && descending) sort_err <= 1'b1;
            if (idx == LAST) begin
              state    <= IDLE;
              idx      <= '0;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              state <= UNLOAD_RD;
              idx   <= idx + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
